// File: rtl/chirp_demodulator.sv
// chirp_demodulator
// Receive-side LoRa symbol demodulator. Each accepted phase sample is
// differenced against the previous one to give an instantaneous frequency.
// The local upchirp ramp and a constant reference offset are then removed,
// which leaves a constant residue r = s << (PHASE_W - sf) for an ideal chirp.
// The residue deviations from the first kept residue (r0) are averaged over
// the symbol, and the rounded top sf bits are emitted as the symbol value.
//
// Ports:
//   clk          sole clock, rising edge
//   chirpReset   asynchronous active-low reset
//   run          level; demodulate symbols back-to-back while high
//   sf           spreading factor, clamped to 6..SF_MAX, latched at sample 0
//   refOffset    constant frequency offset removed from every residue
//   sampleValid  samplePhase is valid this cycle
//   samplePhase  received phase, unsigned modulo 2^PHASE_W
//   symValid     one-cycle pulse when symbol is updated
//   symbol       demodulated symbol, zero-extended above sf bits
//   busy         high whenever the demodulator is not idle
module chirp_demodulator #(
    parameter int PHASE_W = 16,
    parameter int SF_MAX  = 12
) (
    input  logic               clk,
    input  logic               chirpReset,
    input  logic               run,
    input  logic [3:0]         sf,
    input  logic [PHASE_W-1:0] refOffset,
    input  logic               sampleValid,
    input  logic [PHASE_W-1:0] samplePhase,
    output logic               symValid,
    output logic [SF_MAX-1:0]  symbol,
    output logic               busy
);

    localparam int SUM_W = PHASE_W + SF_MAX;
    localparam int SH_W  = $clog2(PHASE_W + 1);

    localparam logic [3:0] SF_LO = 4'd6;
    localparam logic [3:0] SF_HI = 4'(SF_MAX);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FIRST = 3'd1;
    localparam logic [2:0] ST_SEED  = 3'd2;
    localparam logic [2:0] ST_ACC   = 3'd3;
    localparam logic [2:0] ST_FINAL = 3'd4;

    logic [2:0]         state_q,  state_d;
    logic [SF_MAX-1:0]  n_q,      n_d;
    logic [3:0]         sf_q,     sf_d;
    logic [PHASE_W-1:0] prev_q,   prev_d;
    logic [PHASE_W-1:0] r0_q,     r0_d;
    logic [SUM_W-1:0]   sum_q,    sum_d;
    logic [SF_MAX-1:0]  symbol_q, symbol_d;
    logic               sym_valid_q, sym_valid_d;
    logic               busy_q,   busy_d;

    logic [3:0]         sf_clamp_s;
    logic [SH_W-1:0]    sh_s;
    logic [SF_MAX-1:0]  n_last_s;
    logic [PHASE_W-1:0] ramp_s;
    logic [PHASE_W-1:0] r_s;
    logic [PHASE_W-1:0] diff_s;
    logic [SUM_W-1:0]   diff_ext_s;
    logic [PHASE_W-1:0] avg_s;
    logic [PHASE_W-1:0] half_s;
    logic [PHASE_W-1:0] rounded_s;
    logic [SF_MAX-1:0]  sym_calc_s;

    // Clamp the requested spreading factor into the supported range.
    always_comb begin
        if (sf < SF_LO) begin
            sf_clamp_s = SF_LO;
        end else if (sf > SF_HI) begin
            sf_clamp_s = SF_HI;
        end else begin
            sf_clamp_s = sf;
        end
    end

    // Residue datapath: dechirp the current sample and form the rounded average.
    always_comb begin
        sh_s       = SH_W'(PHASE_W) - SH_W'(sf_q);
        n_last_s   = {SF_MAX{1'b1}} >> (SF_HI - sf_q);
        // Ramp term (n-1) << SH; the modular wrap of (s+n) mod N cancels here.
        ramp_s     = PHASE_W'(n_q - {{(SF_MAX-1){1'b0}}, 1'b1}) << sh_s;
        r_s        = samplePhase - prev_q - ramp_s - refOffset;
        // Deviation from r0 is read as signed so residues near the wrap point average correctly.
        diff_s     = r_s - r0_q;
        diff_ext_s = {{SF_MAX{diff_s[PHASE_W-1]}}, diff_s};
        avg_s      = PHASE_W'($signed(sum_q) >>> sf_q);
        half_s     = {{(PHASE_W-1){1'b0}}, 1'b1} << (sh_s - {{(SH_W-1){1'b0}}, 1'b1});
        rounded_s  = r0_q + avg_s + half_s;
        sym_calc_s = SF_MAX'(rounded_s >> sh_s);
    end

    // Next-state and register-update logic for the symbol FSM.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        sf_d        = sf_q;
        prev_d      = prev_q;
        r0_d        = r0_q;
        sum_d       = sum_q;
        symbol_d    = symbol_q;
        sym_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                n_d   = {SF_MAX{1'b0}};
                sum_d = {SUM_W{1'b0}};
                r0_d  = {PHASE_W{1'b0}};
                if (run) begin
                    state_d = ST_FIRST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRST: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (sampleValid) begin
                    prev_d  = samplePhase;
                    sf_d    = sf_clamp_s;
                    n_d     = {{(SF_MAX-1){1'b0}}, 1'b1};
                    state_d = ST_SEED;
                end else begin
                    state_d = ST_FIRST;
                end
            end
            ST_SEED: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (sampleValid) begin
                    prev_d  = samplePhase;
                    r0_d    = r_s;
                    sum_d   = {SUM_W{1'b0}};
                    n_d     = n_q + {{(SF_MAX-1){1'b0}}, 1'b1};
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_SEED;
                end
            end
            ST_ACC: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (sampleValid) begin
                    prev_d = samplePhase;
                    sum_d  = sum_q + diff_ext_s;
                    if (n_q == n_last_s) begin
                        state_d = ST_FINAL;
                    end else begin
                        n_d     = n_q + {{(SF_MAX-1){1'b0}}, 1'b1};
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_FINAL: begin
                symbol_d    = sym_calc_s;
                sym_valid_d = 1'b1;
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (sampleValid) begin
                    // This sample is sample 0 of the next symbol; nothing is dropped.
                    prev_d  = samplePhase;
                    sf_d    = sf_clamp_s;
                    n_d     = {{(SF_MAX-1){1'b0}}, 1'b1};
                    state_d = ST_SEED;
                end else begin
                    state_d = ST_FIRST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge chirpReset) begin
        if (!chirpReset) begin
            state_q     <= ST_IDLE;
            n_q         <= {SF_MAX{1'b0}};
            sf_q        <= 4'd0;
            prev_q      <= {PHASE_W{1'b0}};
            r0_q        <= {PHASE_W{1'b0}};
            sum_q       <= {SUM_W{1'b0}};
            symbol_q    <= {SF_MAX{1'b0}};
            sym_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            sf_q        <= sf_d;
            prev_q      <= prev_d;
            r0_q        <= r0_d;
            sum_q       <= sum_d;
            symbol_q    <= symbol_d;
            sym_valid_q <= sym_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign symValid = sym_valid_q;
    assign symbol   = symbol_q;
    assign busy     = busy_q;

endmodule

// File: doc/chirp_demodulator.md
# chirp_demodulator

Receive-side LoRa symbol demodulator: the inverse of the TX chirp generator. It consumes one received phase sample per chip at the bandwidth rate, with samples arriving on a valid strobe. It differentiates the phase to get instantaneous frequency and removes the local upchirp ramp. It then averages the constant residue over the symbol and emits the recovered `sf`-bit symbol value. It sits after the RX front-end phase extractor (CORDIC) and feeds the deinterleaver/decoder.

## Interface
- `PHASE_W`, 16: phase width; full circle = 2^PHASE_W; must be ≥ SF_MAX+2
- `SF_MAX`, 12: largest spreading factor; also the symbol output width
- `clk`  in  1  sole clock, rising edge
- `chirpReset`  in  1  reset; asynchronous and active-low
- `run`  in  1  level; demodulate symbols back-to-back while high
- `sf`  in  4  spreading factor 6..12; values below 6 clamp to 6, values above 12 clamp to 12; sampled at symbol sample 0
- `refOffset`  in  PHASE_W  constant frequency offset subtracted from every residue (e.g. 0x8000 for a −BW/2 chirp origin)
- `sampleValid`  in  1  `samplePhase` valid this cycle
- `samplePhase`  in  PHASE_W  received phase, unsigned modulo 2^PHASE_W
- `symValid`  out  1  one-cycle pulse; `symbol` is new
- `symbol`  out  SF_MAX  demodulated symbol, zero-extended above `sf` bits
- `busy`  out  1  high in every state except IDLE

## Operation
- N = 2^sf; SH = PHASE_W − sf.
- Sample index n runs 0..N−1 per symbol. For n≥1: d = samplePhase − prevPhase (mod 2^PHASE_W).
  - r = d − ((n−1) << SH) − refOffset (mod 2^PHASE_W).
  - An ideal chirp for symbol s gives r = s<<SH for every n; the wrap of (s+n) mod N cancels in modular arithmetic.
  - The difference at n=0 is discarded because the frequency jumps at the symbol boundary.
- States:
  - IDLE: `run`=1 → FIRST.
  - FIRST: on `sampleValid`, latch phase and `sf`, set n=1 → SEED.
  - SEED: on `sampleValid`, r0 ← r, sum ← 0, n ← 2 → ACC.
  - ACC: on `sampleValid`, sum ← sum + signed(r − r0), where the difference is interpreted as two's-complement PHASE_W. n increments; the sample with n=N−1 → FINAL.
  - FINAL: register `symbol` = ((r0 + (sum >>> sf) + 2^(SH−1)) mod 2^PHASE_W) >> SH and pulse `symValid`. Next state:
    - `run`=0 → IDLE.
    - else `sampleValid` → this sample is sample 0 of the next symbol (latch phase and `sf`, n=1) → SEED.
    - else → FIRST.
- `sum` is a signed PHASE_W+SF_MAX-bit accumulator and cannot overflow (at most 2^SF_MAX−2 terms). Dividing by N instead of N−1 is the decided averaging rule.
- `prevPhase` updates on every accepted sample.
- `run`=0 in FIRST/SEED/ACC: abort to IDLE at the next edge, no `symValid`, partial state discarded.
- A `sf` change mid-symbol is ignored until the next sample 0.
- `sampleValid` in IDLE is ignored.

## Timing
- Reset (asynchronous assert, synchronous release), all registers cleared:
  - state=IDLE, `symValid`=0, `symbol`=0, `busy`=0
  - n=0, sum=0, r0=0, prevPhase=0
- IDLE→FIRST takes one edge after `run` rises; a sample presented on that same edge is ignored.
- Last sample (n=N−1) accepted at edge t → `symbol`/`symValid` registered at edge t+1, with `symValid` high for exactly one cycle.
- Throughput: one sample per cycle sustained. No sample is dropped across symbol boundaries when `run` stays high, including `sampleValid` in FINAL.
- `sampleValid` gaps of any length are allowed; the state holds.
- `symbol` holds its value until the next FINAL.

## Test plan
- sf=7, refOffset=0. Ideal chirp p[n+1] = p[n] + (((s+n) mod 128) << 9), p0=0x1234, s=0 then s=37, continuous valid → `symbol`=0 then 37, each `symValid` exactly 1 cycle after the 128th sample.
- sf=12, s=4095, refOffset=0x8000, generator frequency origin shifted by −BW/2 → `symbol`=4095. Checks wrap-around in both the chirp and the rounding.
- run held, 4 back-to-back sf=8 symbols {0,255,128,1} with no idle cycle and valid asserted during each FINAL → 4 pulses spaced exactly 256 cycles, values correct.
- sf=9, s=300, uniform random ±(2^SH/4) added to each phase → `symbol`=300. Repeat with random `sampleValid` gaps (50% duty) → same result.
- `run` dropped at n=50 of an sf=7 symbol → no `symValid`, `busy`=0 next cycle. `run` reasserted: next full symbol s=5 → 5.
- `chirpReset` asserted asynchronously mid-ACC → all outputs 0 immediately. After release, a full symbol s=99 at sf=10 → 99.
